cordic_vec: RTL and testbench

- Vectoring-mode CORDIC, the inverse of the pipelined rotator.
- Converts a rectangular sample (X, Y) to polar form: magnitude and phase.
- Phase uses the same 32-bit angle format as the rotator, so results feed the rotator/NCO path directly.
- Iterative, one micro-rotation per clock, valid/ready handshake on both sides; used for AGC, FM/PM demod and carrier-phase estimation.

---
 rtl/cordic_vec.sv | 189 ++++++++++++++++++
 tb/tb_cordic_vec.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vec.sv
// Iterative vectoring-mode CORDIC: (Xin, Yin) -> unsigned magnitude and 32-bit phase, one micro-rotation per clock.
// Optional macro CORDIC_VEC_GAIN_COMP_EN adds a COMP state that scales mag by 1/K.
module cordic_vec #(
    parameter int XY_SZ = 16,
    parameter int ITER  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [XY_SZ-1:0] Xin,
    input  logic signed [XY_SZ-1:0] Yin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XY_SZ:0]          mag,
    output logic [31:0]             angle
);
    // Handshake: a sample moves on a rising edge where in_valid & in_ready (IDLE only);
    // a result moves on an edge where out_valid & out_ready (DONE only); both sides hold until then.

    localparam int         W    = XY_SZ + 3;
    localparam logic [4:0] LAST = 5'(ITER - 1);

`ifdef CORDIC_VEC_GAIN_COMP_EN
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_COMP, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
`endif

    state_t state, state_nxt;

    logic signed [W-1:0] x_r, y_r, x_nxt, y_nxt;
    logic signed [W-1:0] xin_ext, yin_ext, x_ld, y_ld;
    logic [31:0]         z_r, z_nxt, z_ld;
    logic [4:0]          cnt;
    logic                zero_r;
    logic                accept;
    logic                last_iter;

    // round(atan(2^-i) / (2*pi) * 2^32)
    function automatic logic [31:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    atan_lut = 32'h2000_0000;
            5'd1:    atan_lut = 32'h12E4_051E;
            5'd2:    atan_lut = 32'h09FB_385B;
            5'd3:    atan_lut = 32'h0511_11D4;
            5'd4:    atan_lut = 32'h028B_0D43;
            5'd5:    atan_lut = 32'h0145_D7E1;
            5'd6:    atan_lut = 32'h00A2_F61E;
            5'd7:    atan_lut = 32'h0051_7C55;
            5'd8:    atan_lut = 32'h0028_BE53;
            5'd9:    atan_lut = 32'h0014_5F2F;
            5'd10:   atan_lut = 32'h000A_2F98;
            5'd11:   atan_lut = 32'h0005_17CC;
            5'd12:   atan_lut = 32'h0002_8BE6;
            5'd13:   atan_lut = 32'h0001_45F3;
            5'd14:   atan_lut = 32'h0000_A2FA;
            5'd15:   atan_lut = 32'h0000_517D;
            5'd16:   atan_lut = 32'h0000_28BE;
            5'd17:   atan_lut = 32'h0000_145F;
            5'd18:   atan_lut = 32'h0000_0A30;
            5'd19:   atan_lut = 32'h0000_0518;
            5'd20:   atan_lut = 32'h0000_028C;
            5'd21:   atan_lut = 32'h0000_0146;
            5'd22:   atan_lut = 32'h0000_00A3;
            5'd23:   atan_lut = 32'h0000_0051;
            5'd24:   atan_lut = 32'h0000_0029;
            5'd25:   atan_lut = 32'h0000_0014;
            5'd26:   atan_lut = 32'h0000_000A;
            5'd27:   atan_lut = 32'h0000_0005;
            5'd28:   atan_lut = 32'h0000_0003;
            5'd29:   atan_lut = 32'h0000_0001;
            default: atan_lut = 32'h0000_0000;
        endcase
    endfunction

    assign accept    = in_valid & in_ready;
    assign last_iter = (cnt == LAST);

    // Pre-rotate into the right half-plane; extended width keeps -(-2^(XY_SZ-1)) exact.
    assign xin_ext = {{3{Xin[XY_SZ-1]}}, Xin};
    assign yin_ext = {{3{Yin[XY_SZ-1]}}, Yin};

    always_comb begin
        x_ld = xin_ext;
        y_ld = yin_ext;
        z_ld = 32'h0000_0000;
        if (Xin[XY_SZ-1]) begin
            if (!Yin[XY_SZ-1]) begin
                x_ld = yin_ext;
                y_ld = -xin_ext;
                z_ld = 32'h4000_0000;
            end else begin
                x_ld = -yin_ext;
                y_ld = xin_ext;
                z_ld = 32'hC000_0000;
            end
        end
    end

    always_comb begin
        if (!y_r[W-1]) begin
            x_nxt = x_r + (y_r >>> cnt);
            y_nxt = y_r - (x_r >>> cnt);
            z_nxt = z_r + atan_lut(cnt);
        end else begin
            x_nxt = x_r - (y_r >>> cnt);
            y_nxt = y_r + (x_r >>> cnt);
            z_nxt = z_r - atan_lut(cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_ITER;
            end
            S_ITER: begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                if (last_iter) state_nxt = S_COMP;
`else
                if (last_iter) state_nxt = S_DONE;
`endif
            end
`ifdef CORDIC_VEC_GAIN_COMP_EN
            S_COMP: state_nxt = S_DONE;
`endif
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            cnt    <= '0;
            zero_r <= 1'b0;
        end else if (accept) begin
            x_r    <= x_ld;
            y_r    <= y_ld;
            z_r    <= z_ld;
            cnt    <= '0;
            zero_r <= (Xin == '0) && (Yin == '0);
        end else if (state == S_ITER) begin
            x_r <= x_nxt;
            y_r <= y_nxt;
            z_r <= z_nxt;
            cnt <= cnt + 5'd1;
        end
    end

`ifdef CORDIC_VEC_GAIN_COMP_EN
    // 19898 / 2^15 ~ 1/K; X is non-negative here, so the slice truncates toward zero.
    localparam logic signed [W+15:0] INV_K = 19898;
    logic signed [W+15:0] comp_prod;
    assign comp_prod = (W+16)'(x_r) * INV_K;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag   <= '0;
            angle <= '0;
`ifdef CORDIC_VEC_GAIN_COMP_EN
        end else if (state == S_COMP) begin
            mag   <= zero_r ? '0 : comp_prod[XY_SZ+15:15];
            angle <= zero_r ? '0 : z_r;
`else
        end else if (state == S_ITER && last_iter) begin
            mag   <= zero_r ? '0 : x_nxt[XY_SZ:0];
            angle <= zero_r ? '0 : z_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_cordic_vec.sv
// Bench for cordic_vec: directed corners, backpressure, mid-run reset and random samples,
// scored against an arithmetic CORDIC model and the ideal polar values.
`timescale 1ns/1ps
module tb_cordic_vec;
    localparam int  XY_SZ   = 16;
    localparam int  ITER    = 16;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int  LAT     = ITER + 1;
`else
    localparam int  LAT     = ITER;
`endif
    localparam int  EXP_W   = XY_SZ + 1 + 32;
    localparam real PI      = 3.14159265358979323846;
    localparam real TWO32   = 4294967296.0;
    // integer truncation inside each micro-rotation biases the magnitude by about one LSB per step
    localparam int  MAG_TOL = ITER + 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b0;
    logic signed [XY_SZ-1:0] Xin = '0;
    logic signed [XY_SZ-1:0] Yin = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic [XY_SZ:0]          mag;
    logic [31:0]             angle;

    cordic_vec #(.XY_SZ(XY_SZ), .ITER(ITER)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .Xin(Xin), .Yin(Yin),
        .out_valid(out_valid), .out_ready(out_ready), .mag(mag), .angle(angle)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int             errors = 0;
    int             checks = 0;
    logic [EXP_W-1:0] exp_q[$];
    longint         ideal_mag_q[$];
    longint         ideal_ang_q[$];
    longint         ang_tol_q[$];
    bit             ideal_en_q[$];
    logic [31:0]    atan_tab[ITER];
    real            kgain;
    bit             bp = 1'b0;
    bit             rand_ready = 1'b0;

    task automatic check(input string name, input longint got, input longint want, input longint tol);
        longint d;
        d = got - want;
        if (d < 0) d = -d;
        checks++;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, got, want, tol, $time);
        end
    endtask

    // Spec-level CORDIC: quadrant fold, then ITER micro-rotations on plain integers.
    function automatic logic [EXP_W-1:0] model(input int xi, input int yi);
        longint      x, y, xn, yn;
        logic [31:0] z;
        logic [XY_SZ:0] m;
        if (xi >= 0)      begin x = xi;  y = yi;  z = 32'h0000_0000; end
        else if (yi >= 0) begin x = yi;  y = -xi; z = 32'h4000_0000; end
        else              begin x = -yi; y = xi;  z = 32'hC000_0000; end
        for (int i = 0; i < ITER; i++) begin
            if (y >= 0) begin xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_tab[i]; end
            else        begin xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_tab[i]; end
            x = xn;
            y = yn;
        end
`ifdef CORDIC_VEC_GAIN_COMP_EN
        x = (x * 19898) >>> 15;
`endif
        m = x[XY_SZ:0];
        if (xi == 0 && yi == 0) return '0;
        return {m, z};
    endfunction

    task automatic push_exp(input int xi, input int yi);
        real r, a;
        exp_q.push_back(model(xi, yi));
        r = $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
        a = $atan2(real'(yi), real'(xi)) / (2.0 * PI) * TWO32;
        if (a < 0.0) a = a + TWO32;
`ifdef CORDIC_VEC_GAIN_COMP_EN
        ideal_mag_q.push_back(longint'(r));
`else
        ideal_mag_q.push_back(longint'(kgain * r));
`endif
        ideal_ang_q.push_back(longint'(a));
        ideal_en_q.push_back(r > 0.0);
        // phase resolution is limited by one LSB per step on a vector of length K*r
        ang_tol_q.push_back(r > 0.0 ? longint'(65536.0 + 2.0 * ITER * TWO32 / (2.0 * PI) / (kgain * r)) : 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input int xi, input int yi, input bit expect_out, input bit measure);
        int guard = 0;
        int lat = 0;
        bit busy_bad = 1'b0;
        @(negedge clk);
        while (!in_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1, 0);
            return;
        end
        if (expect_out) push_exp(xi, yi);
        in_valid = 1'b1;
        Xin = 16'(xi);
        Yin = 16'(yi);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        Xin = 16'($urandom);
        Yin = 16'($urandom);
        if (measure) begin
            while (lat <= LAT + 4) begin
                @(negedge clk);
                if (out_valid) break;
                if (in_ready) busy_bad = 1'b1;
                lat++;
            end
            check("latency", lat, LAT, 0);
            check("in_ready_busy", busy_bad, 0, 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [EXP_W-1:0] e;
        longint im, ia, tol;
        bit en;
        int d;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0, 0);
                end else begin
                    e   = exp_q.pop_front();
                    im  = ideal_mag_q.pop_front();
                    ia  = ideal_ang_q.pop_front();
                    tol = ang_tol_q.pop_front();
                    en  = ideal_en_q.pop_front();
                    check("mag", longint'(mag), longint'(e[EXP_W-1:32]), 0);
                    check("angle", longint'(angle), longint'(e[31:0]), 0);
                    if (en) begin
                        check("mag_ideal", longint'(mag), im, MAG_TOL);
                        d = $signed(angle - 32'(ia));
                        check("angle_ideal", longint'(d), 0, tol);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int dir_x[10] = '{1000, 0, -1000, 1000, -1000, -32768, 0, 32767, -32768, 1};
    int dir_y[10] = '{0, 1000, 0, 1000, -1000, -32768, 0, -32768, 0, -1};
    int corner[5] = '{-32768, 32767, 0, -1, 1};

    initial begin
        logic [EXP_W-1:0] hold;
        int guard;
        int xi, yi;
        logic signed [15:0] t;

        kgain = 1.0;
        for (int i = 0; i < ITER; i++) begin
            atan_tab[i] = 32'($rtoi($atan(1.0 / (2.0 ** i)) / (2.0 * PI) * TWO32 + 0.5));
            kgain = kgain * $sqrt(1.0 + 1.0 / (4.0 ** i));
        end

        // reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1, 0);
        check("rst_out_valid", out_valid, 0, 0);
        check("rst_mag", mag, 0, 0);
        check("rst_angle", angle, 0, 0);
        rst_n = 1'b1;

        // directed corners, latency measured on each
        for (int i = 0; i < 10; i++) send(dir_x[i], dir_y[i], 1'b1, 1'b1);

        // backpressure: result must hold while out_ready is low
        bp = 1'b1;
        send(700, -300, 1'b1, 1'b1);
        hold = exp_q[0];
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_out_valid", out_valid, 1, 0);
            check("bp_in_ready", in_ready, 0, 0);
            check("bp_mag", mag, longint'(hold[EXP_W-1:32]), 0);
            check("bp_angle", angle, longint'(hold[31:0]), 0);
        end
        bp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("release_in_ready", in_ready, 1, 0);
        check("release_out_valid", out_valid, 0, 0);

        // reset during iteration 7 discards the sample
        send(-20000, 12345, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0, 0);
        check("midrst_in_ready", in_ready, 1, 0);
        check("midrst_mag", mag, 0, 0);
        check("midrst_angle", angle, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 500, 1'b1, 1'b1);

        // random samples with random downstream stalls
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            t = 16'($urandom);
            xi = (n % 5 == 0) ? corner[$urandom_range(0, 4)] : int'(t);
            t = 16'($urandom);
            yi = (n % 7 == 0) ? corner[$urandom_range(0, 4)] : int'(t);
            send(xi, yi, 1'b1, 1'b0);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_left", exp_q.size(), 0, 0);
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
